// File: rtl/core_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// core_ctrl_pkg
// Shared definitions for the core instruction sequencer:
//   - array/tile geometry and per-phase cycle counts
//   - sequencer state encoding
//   - bit positions of every field in the 64-bit core instruction word
//   - kernel index split (kij -> kx, ky) as a constant lookup
// ---------------------------------------------------------------------------
package core_ctrl_pkg;

    localparam int ROW      = 8;
    localparam int COL      = 8;
    localparam int LEN_NIJ  = 36;
    localparam int IFMAP_W  = 6;
    localparam int KERNEL_W = 3;
    localparam int OFMAP_W  = IFMAP_W - KERNEL_W + 1;
    localparam int GAP_LEN  = 11;

    localparam logic [10:0] WGT_BASE = 11'd1024;

    // Last value of the per-phase cycle counter (counter starts at 0).
    localparam logic [5:0] W_L0_LAST   = 6'(COL);
    localparam logic [5:0] K_LOAD_LAST = 6'(ROW + COL - 1);
    localparam logic [5:0] GAP_LAST    = 6'(GAP_LEN - 1);
    localparam logic [5:0] STREAM_LAST = 6'(LEN_NIJ - 1);
    localparam logic [5:0] EXEC_LAST   = 6'(LEN_NIJ + ROW + COL - 1);
    localparam logic [5:0] DRAIN_LAST  = 6'd1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_W_PRE  = 4'd1,
        S_W_L0   = 4'd2,
        S_K_PRE  = 4'd3,
        S_K_LOAD = 4'd4,
        S_GAP    = 4'd5,
        S_X_PRE  = 4'd6,
        S_EXEC   = 4'd7,
        S_DRAIN  = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    // Instruction word bit map.
    localparam int B_DEBUG    = 63;
    localparam int B_SFU_PASS = 34;
    localparam int B_ACC      = 33;
    localparam int B_CEN_PMEM = 32;
    localparam int B_WEN_PMEM = 31;
    localparam int B_APM_HI   = 30;
    localparam int B_APM_LO   = 20;
    localparam int B_CEN_XMEM = 19;
    localparam int B_WEN_XMEM = 18;
    localparam int B_AXM_HI   = 17;
    localparam int B_AXM_LO   = 7;
    localparam int B_OFIFO_RD = 6;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXECUTE  = 1;
    localparam int B_LOAD     = 0;

    // Kernel column offset for kij 0..8.
    function automatic logic [1:0] kx_of(input logic [3:0] k);
        case (k)
            4'd0, 4'd3, 4'd6: kx_of = 2'd0;
            4'd1, 4'd4, 4'd7: kx_of = 2'd1;
            4'd2, 4'd5, 4'd8: kx_of = 2'd2;
            default:          kx_of = 2'd0;
        endcase
    endfunction

    // Kernel row offset for kij 0..8.
    function automatic logic [1:0] ky_of(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd2: ky_of = 2'd0;
            4'd3, 4'd4, 4'd5: ky_of = 2'd1;
            4'd6, 4'd7, 4'd8: ky_of = 2'd2;
            default:          ky_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/core_ctrl_onij_mapper.sv
// ---------------------------------------------------------------------------
// onij_mapper
// Tracks the input-pixel position (nx, ny) of the next OFIFO row and maps it
// to an output-pixel address for the current kernel position.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart counting at nij = 0
//   advance    : one OFIFO row consumed this cycle
//   kij        : kernel index of the current pass
//   onij       : output pixel address (onijx + onijy*4)
//   valid      : current nij lands inside the ofmap and is within the tile
// ---------------------------------------------------------------------------
module onij_mapper
    import core_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    input  logic [3:0] kij,
    output logic [3:0] onij,
    output logic       valid
);

    logic [2:0] nx_r;
    logic [2:0] ny_r;
    logic [3:0] ox_s;
    logic [3:0] oy_s;

    // Raster position counter; ny == IFMAP_W means the tile is exhausted and the count saturates.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            nx_r <= 3'd0;
            ny_r <= 3'd0;
        end else if (advance && (ny_r != 3'(IFMAP_W))) begin
            if (nx_r == 3'(IFMAP_W - 1)) begin
                nx_r <= 3'd0;
                ny_r <= ny_r + 3'd1;
            end else begin
                nx_r <= nx_r + 3'd1;
            end
        end
    end

    // Shift by the kernel offset; a negative or too-large result wraps into bits [3:2].
    always_comb begin
        ox_s  = {1'b0, nx_r} - {2'b00, kx_of(kij)};
        oy_s  = {1'b0, ny_r} - {2'b00, ky_of(kij)};
        onij  = {oy_s[1:0], ox_s[1:0]};
        valid = (ox_s[3:2] == 2'b00) && (oy_s[3:2] == 2'b00) && (ny_r < 3'(IFMAP_W));
    end

endmodule

// File: rtl/core_ctrl.sv
// ---------------------------------------------------------------------------
// core_ctrl
// Instruction sequencer for one kernel position (kij) of a 3x3 conv over a
// 6x6 ifmap. Each start runs: weight load into L0, kernel load into the PE
// array, settle gap, activation streaming, drain, with OFIFO rows written or
// accumulated into psum SRAM at their output-pixel address.
//   clk         : clock
//   reset       : synchronous active-high reset
//   start       : begin a pass (only honoured in IDLE)
//   kij         : kernel index 0..8, latched on accepted start
//   ofifo_valid : core OFIFO holds a complete row
//   inst        : 64-bit core instruction word
//   busy        : pass in progress
//   done        : one-cycle pulse at pass end
//   err         : one-cycle pulse when start arrives with kij > 8
//   dbg_cycles  : (CORE_CTRL_DEBUG_EN only) busy-cycle count of last pass
// Build option: define CORE_CTRL_DEBUG_EN to flag EXEC/DRAIN on inst[63] and
// expose dbg_cycles.
// ---------------------------------------------------------------------------
module core_ctrl
    import core_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  kij,
    input  logic        ofifo_valid,
    output logic [63:0] inst,
    output logic        busy,
    output logic        done,
    output logic        err
`ifdef CORE_CTRL_DEBUG_EN
    ,
    output logic [15:0] dbg_cycles
`endif
);

    state_t      state_r;
    logic [5:0]  cnt_r;
    logic [3:0]  kij_r;
    logic [10:0] a_xmem_r;
    logic        cen_xmem_r;
    logic        wen_xmem_r;
    logic        l0_rd_r;
    logic        l0_wr_r;
    logic        execute_r;
    logic        load_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic        dbg_bit_s;

    logic        start_ok_s;
    logic        pop_s;
    logic [3:0]  onij_s;
    logic        map_valid_s;

    logic        ofifo_rd_s;
    logic        cen_pmem_s;
    logic        wen_pmem_s;
    logic        acc_s;
    logic        sfu_s;
    logic [10:0] a_pmem_s;

    assign start_ok_s = (state_r == S_IDLE) && start && (kij <= 4'd8);
    assign pop_s      = ofifo_valid && ((state_r == S_EXEC) || (state_r == S_DRAIN));

    onij_mapper u_onij_mapper (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_ok_s),
        .advance (pop_s),
        .kij     (kij_r),
        .onij    (onij_s),
        .valid   (map_valid_s)
    );

    // Sequencer FSM; control fields are loaded with the values of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            cnt_r      <= 6'd0;
            kij_r      <= 4'd0;
            a_xmem_r   <= 11'd0;
            cen_xmem_r <= 1'b1;
            wen_xmem_r <= 1'b0;
            l0_rd_r    <= 1'b0;
            l0_wr_r    <= 1'b0;
            execute_r  <= 1'b0;
            load_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    cnt_r <= 6'd0;
                    if (start) begin
                        if (kij <= 4'd8) begin
                            state_r    <= S_W_PRE;
                            kij_r      <= kij;
                            busy_r     <= 1'b1;
                            wen_xmem_r <= 1'b1;
                            cen_xmem_r <= 1'b0;
                            a_xmem_r   <= WGT_BASE;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                S_W_PRE: begin
                    state_r <= S_W_L0;
                    l0_wr_r <= 1'b1;
                end
                S_W_L0: begin
                    if (cnt_r == W_L0_LAST) begin
                        state_r    <= S_K_PRE;
                        cnt_r      <= 6'd0;
                        l0_wr_r    <= 1'b0;
                        l0_rd_r    <= 1'b1;
                        cen_xmem_r <= 1'b1;
                    end else begin
                        cnt_r    <= cnt_r + 6'd1;
                        a_xmem_r <= a_xmem_r + 11'd1;
                    end
                end
                S_K_PRE: begin
                    state_r <= S_K_LOAD;
                    load_r  <= 1'b1;
                end
                S_K_LOAD: begin
                    if (cnt_r == K_LOAD_LAST) begin
                        state_r <= S_GAP;
                        cnt_r   <= 6'd0;
                        load_r  <= 1'b0;
                        l0_rd_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        state_r    <= S_X_PRE;
                        cnt_r      <= 6'd0;
                        a_xmem_r   <= 11'd0;
                        cen_xmem_r <= 1'b0;
                        l0_wr_r    <= 1'b1;
                        l0_rd_r    <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                S_X_PRE: begin
                    state_r   <= S_EXEC;
                    execute_r <= 1'b1;
                    a_xmem_r  <= a_xmem_r + 11'd1;
                end
                S_EXEC: begin
                    // Address runs 1..LEN_NIJ while streaming, then freezes for the flush.
                    if (cnt_r < STREAM_LAST) begin
                        a_xmem_r <= a_xmem_r + 11'd1;
                    end
                    if (cnt_r == STREAM_LAST) begin
                        execute_r <= 1'b0;
                        l0_rd_r   <= 1'b0;
                    end
                    if (cnt_r == EXEC_LAST) begin
                        state_r <= S_DRAIN;
                        cnt_r   <= 6'd0;
                    end else begin
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                S_DRAIN: begin
                    if (cnt_r == DRAIN_LAST) begin
                        state_r    <= S_DONE;
                        cnt_r      <= 6'd0;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        cen_xmem_r <= 1'b1;
                        l0_wr_r    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    cnt_r   <= 6'd0;
                end
            endcase
        end
    end

`ifdef CORE_CTRL_DEBUG_EN
    logic        dbg_bit_r;
    logic [15:0] dbg_cycles_r;

    // Debug flag tracks EXEC/DRAIN; cycle counter measures the busy window of the last pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_bit_r    <= 1'b0;
            dbg_cycles_r <= 16'd0;
        end else begin
            if (state_r == S_X_PRE) begin
                dbg_bit_r <= 1'b1;
            end else if ((state_r == S_DRAIN) && (cnt_r == DRAIN_LAST)) begin
                dbg_bit_r <= 1'b0;
            end
            if (start_ok_s) begin
                dbg_cycles_r <= 16'd0;
            end else if (busy_r) begin
                dbg_cycles_r <= dbg_cycles_r + 16'd1;
            end
        end
    end

    assign dbg_bit_s  = dbg_bit_r;
    assign dbg_cycles = dbg_cycles_r;
`else
    assign dbg_bit_s = 1'b0;
`endif

    // Psum SRAM group follows ofifo_valid in the same cycle so a row is written as it is popped.
    always_comb begin
        if (pop_s) begin
            ofifo_rd_s = 1'b1;
            cen_pmem_s = ~map_valid_s;
            wen_pmem_s = map_valid_s;
            a_pmem_s   = map_valid_s ? {7'd0, onij_s} : 11'd0;
            acc_s      = (kij_r != 4'd0);
            sfu_s      = (kij_r == 4'd0);
        end else begin
            ofifo_rd_s = 1'b0;
            cen_pmem_s = 1'b1;
            wen_pmem_s = 1'b0;
            a_pmem_s   = 11'd0;
            acc_s      = 1'b0;
            sfu_s      = 1'b0;
        end
    end

    // Assemble the instruction word; unlisted bits stay zero.
    always_comb begin
        inst                      = 64'd0;
        inst[B_DEBUG]             = dbg_bit_s;
        inst[B_SFU_PASS]          = sfu_s;
        inst[B_ACC]               = acc_s;
        inst[B_CEN_PMEM]          = cen_pmem_s;
        inst[B_WEN_PMEM]          = wen_pmem_s;
        inst[B_APM_HI:B_APM_LO]   = a_pmem_s;
        inst[B_CEN_XMEM]          = cen_xmem_r;
        inst[B_WEN_XMEM]          = wen_xmem_r;
        inst[B_AXM_HI:B_AXM_LO]   = a_xmem_r;
        inst[B_OFIFO_RD]          = ofifo_rd_s;
        inst[B_L0_RD]             = l0_rd_r;
        inst[B_L0_WR]             = l0_wr_r;
        inst[B_EXECUTE]           = execute_r;
        inst[B_LOAD]              = load_r;
    end

    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_r;

endmodule

// File: tb/tb_core_ctrl.sv
// ---------------------------------------------------------------------------
// tb_core_ctrl
// Scoreboard bench for core_ctrl. Stimulus pushes per-cycle expectations and
// per-pop psum expectations into queues; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_core_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  kij;
    logic        ofifo_valid;
    logic [63:0] inst;
    logic        busy;
    logic        done;
    logic        err;
`ifdef CORE_CTRL_DEBUG_EN
    logic [15:0] dbg_cycles;
    localparam logic DBG = 1'b1;
`else
    localparam logic DBG = 1'b0;
`endif

    core_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .kij         (kij),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .err         (err)
`ifdef CORE_CTRL_DEBUG_EN
        ,
        .dbg_cycles  (dbg_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] mask;
        logic [63:0] val;
        logic        busy;
        logic        done;
        logic        err;
        string       name;
    } cyc_t;

    typedef struct {
        logic        wr;
        logic [10:0] a;
        logic        full;
        logic        acc;
        logic        sfu;
        string       name;
    } pop_t;

    cyc_t cyc_q[$];
    pop_t pop_q[$];
    cyc_t mon_c;
    pop_t mon_p;
    int   checks = 0;
    int   errors = 0;

    localparam logic [63:0] RST_INST = 64'h0000_0001_0008_0000;
    localparam logic [63:0] M_CTRL   = 64'h8000_0000_000C_004F; // dbg, CEN/WEN_xmem, ofifo_rd, l0/exec/load
    localparam logic [63:0] M_AX     = 64'h0000_0000_0003_FF80; // A_xmem
    localparam logic [63:0] M_IDLE   = 64'h8000_0000_0008_004F; // as M_CTRL without WEN_xmem

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void push_cyc(input logic [63:0] m, input logic [63:0] v,
                                     input logic b, input logic d, input logic e, input string n);
        cyc_t x;
        x.mask = m; x.val = v; x.busy = b; x.done = d; x.err = e; x.name = n;
        cyc_q.push_back(x);
    endfunction

    // Expected psum response for the nij-th pop, from a divide/modulo model of the tile.
    function automatic void push_pop(input int k, input int nij, input string n);
        pop_t p;
        int nx, ny, ox, oy;
        p.name = n;
        if (nij < 36) begin
            nx     = nij % 6;
            ny     = nij / 6;
            ox     = nx - (k % 3);
            oy     = ny - (k / 3);
            p.wr   = (ox >= 0) && (ox < 4) && (oy >= 0) && (oy < 4);
            p.a    = p.wr ? 11'(ox + oy * 4) : 11'd0;
            p.full = 1'b1;
            p.acc  = (k != 0);
            p.sfu  = (k == 0);
        end else begin
            p.wr   = 1'b0;
            p.a    = 11'd0;
            p.full = 1'b0;
            p.acc  = 1'b0;
            p.sfu  = 1'b0;
        end
        pop_q.push_back(p);
    endfunction

    // Monitor: compare every pushed cycle expectation and every OFIFO pop.
    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            mon_c = cyc_q.pop_front();
            chk({mon_c.name, "_inst"}, inst & mon_c.mask, mon_c.val & mon_c.mask);
            chk({mon_c.name, "_busy"}, {63'd0, busy}, {63'd0, mon_c.busy});
            chk({mon_c.name, "_done"}, {63'd0, done}, {63'd0, mon_c.done});
            chk({mon_c.name, "_err"},  {63'd0, err},  {63'd0, mon_c.err});
        end
        if (inst[6]) begin
            if (pop_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual=ofifo_rd_1 required=no_pop");
            end else begin
                mon_p = pop_q.pop_front();
                chk({mon_p.name, "_cen_pmem"}, {63'd0, inst[32]}, {63'd0, ~mon_p.wr});
                chk({mon_p.name, "_wen_pmem"}, {63'd0, inst[31]}, {63'd0, mon_p.wr});
                if (mon_p.wr) begin
                    chk({mon_p.name, "_a_pmem"}, {53'd0, inst[30:20]}, {53'd0, mon_p.a});
                end
                if (mon_p.full) begin
                    chk({mon_p.name, "_acc"}, {63'd0, inst[33]}, {63'd0, mon_p.acc});
                    chk({mon_p.name, "_sfu"}, {63'd0, inst[34]}, {63'd0, mon_p.sfu});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One kij pass. Entered at the start of an unchecked IDLE cycle, leaves likewise.
    task automatic run_pass(input int k, input int pop_from, input int pop_n,
                            input int rst_at, input bit extra, input string tag);
        logic [63:0] m, v;
        logic        b, d, pop_now;
        int          nij;
        nij = 0;
        start = 1'b1;
        kij   = k[3:0];
        push_cyc(M_CTRL & ~(64'd1 << 18) & ~(64'd1 << 63), 64'h0000_0000_0008_0000,
                 1'b0, 1'b0, 1'b0, {tag, "_req"});
        step();
        start = 1'b0;
        for (int c = 0; c <= 94; c++) begin
            m = M_CTRL; v = 64'd0; v[19] = 1'b1; v[18] = 1'b1; b = 1'b1; d = 1'b0;
            if (c == 0) begin
                m |= M_AX; v[17:7] = 11'd1024; v[19] = 1'b0;
            end else if (c <= 9) begin
                m |= M_AX; v[17:7] = 11'(1024 + c - 1); v[19] = 1'b0; v[2] = 1'b1;
            end else if (c == 10) begin
                v[3] = 1'b1;
            end else if (c <= 26) begin
                v[3] = 1'b1; v[0] = 1'b1;
            end else if (c <= 37) begin
                v[0] = 1'b0;
            end else if (c == 38) begin
                m |= M_AX; v[17:7] = 11'd0; v[19] = 1'b0; v[2] = 1'b1; v[3] = 1'b1;
            end else if (c <= 74) begin
                m |= M_AX; v[17:7] = 11'(c - 38); v[19] = 1'b0;
                v[1] = 1'b1; v[2] = 1'b1; v[3] = 1'b1; v[63] = DBG;
            end else if (c <= 92) begin
                m |= M_AX; m &= ~(64'd1 << 2); v[17:7] = 11'd36; v[19] = 1'b0; v[63] = DBG;
            end else if (c == 93) begin
                m = 64'd1 << 6; b = 1'b0; d = 1'b1;
            end else begin
                m = M_IDLE; b = 1'b0;
            end
            pop_now = (c >= pop_from) && (c < pop_from + pop_n);
            v[6] = pop_now;
            ofifo_valid = pop_now || (extra && (c == 30));
            if (extra && (c == 20)) begin
                start = 1'b1; kij = 4'd1;
            end else begin
                start = 1'b0;
            end
            if (pop_now) begin
                push_pop(k, nij, $sformatf("%s_nij%0d", tag, nij));
                nij++;
            end
            push_cyc(m, v, b, d, 1'b0, $sformatf("%s_c%0d", tag, c));
            if (c == rst_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                ofifo_valid = 1'b0;
                push_cyc({64{1'b1}}, RST_INST, 1'b0, 1'b0, 1'b0, {tag, "_abort"});
                step();
                return;
            end
            step();
        end
        ofifo_valid = 1'b0;
    endtask

    task automatic err_test();
        start = 1'b1;
        kij   = 4'd9;
        push_cyc(M_IDLE, 64'h0000_0000_0008_0000, 1'b0, 1'b0, 1'b0, "err_req");
        step();
        start = 1'b0;
        kij   = 4'd0;
        push_cyc(M_IDLE, 64'h0000_0000_0008_0000, 1'b0, 1'b0, 1'b1, "err_pulse");
        step();
        push_cyc(M_IDLE, 64'h0000_0000_0008_0000, 1'b0, 1'b0, 1'b0, "err_after");
        step();
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        kij         = 4'd0;
        ofifo_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ofifo_valid = (i == 3);
            push_cyc({64{1'b1}}, RST_INST, 1'b0, 1'b0, 1'b0, $sformatf("rst_idle%0d", i));
            step();
        end
        ofifo_valid = 1'b0;

        run_pass(0, 0,  0,  -1, 1'b1, "p1_k0_nopop");
        run_pass(0, 45, 38, -1, 1'b0, "p2_k0");
        run_pass(4, 40, 38, -1, 1'b0, "p3_k4");
        err_test();
        run_pass(2, 40, 10, 49, 1'b0, "p4_k2_rst");
        run_pass(8, 50, 38, -1, 1'b0, "p5_k8");

        step();
        step();
        chk("cyc_queue_empty", 64'(cyc_q.size()), 64'd0);
        chk("pop_queue_empty", 64'(pop_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
